// File: rtl/exe_muldiv_unit.sv
// exe_muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU unit producing HI/LO with pipeline stall
//   Ports: cpu_clk_50M/cpu_rst (sync, active-high); start_i/op_i/src1_i/src2_i issue an op;
//   flush_i cancels; busy_o/stall_o freeze the pipe; valid_o strobes hi_o/lo_o; div_zero_o flags x/0.
//   Optional MULDIV_FAST_MUL_EN: single-cycle array multiply instead of the iterative one.
module exe_muldiv_unit #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = $clog2(DATA_W) + 1
) (
   input  logic              cpu_clk_50M,
   input  logic              cpu_rst,
   input  logic              start_i,
   input  logic [1:0]        op_i,
   input  logic [DATA_W-1:0] src1_i,
   input  logic [DATA_W-1:0] src2_i,
   input  logic              flush_i,
   output logic              busy_o,
   output logic              stall_o,
   output logic              valid_o,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o,
   output logic              div_zero_o
);
   typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;
   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  div_q, div_d, dz_q, dz_d, negq_q, negq_d, negr_q, negr_d;
   logic                  valid_q, valid_d, div_zero_q, div_zero_d;
   logic [DATA_W-1:0]     b_q, b_d, hi_q, hi_d, lo_q, lo_d;
   logic [2*DATA_W-1:0]   acc_q, acc_d;
   logic [DATA_W:0]       rem_q, rem_d;
   logic                  s1n, s2n;
   logic [DATA_W-1:0]     a_abs, b_abs, quo_s, rem_s;
   logic [DATA_W:0]       sum;
   logic [DATA_W+1:0]     trial, diff;
   logic [2*DATA_W-1:0]   prod_s;
   assign s1n    = ~op_i[0] & src1_i[DATA_W-1];
   assign s2n    = ~op_i[0] & src2_i[DATA_W-1];
   assign a_abs  = s1n ? -src1_i : src1_i;
   assign b_abs  = s2n ? -src2_i : src2_i;
   // multiply: acc = {partial hi, remaining multiplier bits}; add then shift right
   assign sum    = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, b_q};
   // divide: acc[DATA_W-1:0] shifts the dividend out and the quotient in
   assign trial  = {rem_q, acc_q[DATA_W-1]};
   assign diff   = trial - {2'b0, b_q};
   assign prod_s = negq_q ? -acc_q : acc_q;
   assign quo_s  = negq_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
   assign rem_s  = negr_q ? -rem_q[DATA_W-1:0] : rem_q[DATA_W-1:0];
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      div_d      = div_q;
      dz_d       = dz_q;
      negq_d     = negq_q;
      negr_d     = negr_q;
      b_d        = b_q;
      acc_d      = acc_q;
      rem_d      = rem_q;
      valid_d    = 1'b0;
      div_zero_d = 1'b0;
      hi_d       = hi_q;
      lo_d       = lo_q;
      case (state_q)
         IDLE: if (start_i) begin
            state_d = CALC;
            cnt_d   = '0;
            div_d   = op_i[1];
            dz_d    = op_i[1] && (src2_i == '0);
            negq_d  = s1n ^ s2n;
            negr_d  = s1n;
            b_d     = b_abs;
            acc_d   = {{DATA_W{1'b0}}, a_abs};
            rem_d   = '0;
            // divide by zero keeps the raw dividend for hi_o and skips the iteration
            if (dz_d) begin
               state_d = SIGN;
               acc_d   = {{DATA_W{1'b0}}, src1_i};
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!op_i[1]) begin
               state_d = SIGN;
               acc_d   = {{DATA_W{1'b0}}, a_abs} * {{DATA_W{1'b0}}, b_abs};
            end
`endif
         end
         CALC: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (div_q) begin
               rem_d = diff[DATA_W+1] ? trial[DATA_W:0] : diff[DATA_W:0];
               acc_d = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-2:0], ~diff[DATA_W+1]};
            end else
               acc_d = acc_q[0] ? {sum, acc_q[DATA_W-1:1]} : {1'b0, acc_q[2*DATA_W-1:1]};
            if (cnt_q == CNT_W'(DATA_W-1))
               state_d = SIGN;
         end
         SIGN: begin
            state_d    = IDLE;
            valid_d    = 1'b1;
            div_zero_d = dz_q;
            hi_d       = dz_q ? acc_q[DATA_W-1:0] : div_q ? rem_s : prod_s[2*DATA_W-1:DATA_W];
            lo_d       = dz_q ? '1 : div_q ? quo_s : prod_s[DATA_W-1:0];
         end
         default: state_d = IDLE;
      endcase
      if (flush_i) begin
         state_d    = IDLE;
         valid_d    = 1'b0;
         div_zero_d = 1'b0;
         hi_d       = hi_q;
         lo_d       = lo_q;
      end
   end
   always_ff @(posedge cpu_clk_50M) begin
      if (cpu_rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         div_q      <= 1'b0;
         dz_q       <= 1'b0;
         negq_q     <= 1'b0;
         negr_q     <= 1'b0;
         b_q        <= '0;
         acc_q      <= '0;
         rem_q      <= '0;
         valid_q    <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         dz_q       <= dz_d;
         negq_q     <= negq_d;
         negr_q     <= negr_d;
         b_q        <= b_d;
         acc_q      <= acc_d;
         rem_q      <= rem_d;
         valid_q    <= valid_d;
         div_zero_q <= div_zero_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
      end
   end
   assign busy_o     = state_q != IDLE;
   assign stall_o    = ((state_q == IDLE) & start_i) | busy_o;
   assign valid_o    = valid_q;
   assign div_zero_o = div_zero_q;
   assign hi_o       = hi_q;
   assign lo_o       = lo_q;
endmodule

// File: tb/tb_exe_muldiv_unit.sv
// tb_exe_muldiv_unit: directed self-checking bench for exe_muldiv_unit
module tb_exe_muldiv_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] src1 = '0, src2 = '0;
   logic        flush = 1'b0;
   logic        busy, stall, valid, dz;
   logic [31:0] hi, lo;
   int          tests = 0, fails = 0;
`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 2;
`else
   localparam int MUL_LAT = 34;
`endif
   exe_muldiv_unit #(.DATA_W(32)) dut (
      .cpu_clk_50M(clk), .cpu_rst(rst), .start_i(start), .op_i(op),
      .src1_i(src1), .src2_i(src2), .flush_i(flush), .busy_o(busy),
      .stall_o(stall), .valid_o(valid), .hi_o(hi), .lo_o(lo), .div_zero_o(dz)
   );
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   // issue in the current cycle, advance to cycle 1, then scramble the operands
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      op = o; src1 = a; src2 = b; start = 1'b1;
      #1 chk("stall_on_issue", {63'd0, stall}, 64'd1);
      tick();
      start = 1'b0; src1 = 32'hDEADBEEF; src2 = 32'h12345678; op = 2'b10;
   endtask
   // from cycle 1: busy without valid until cycle lat, then a lone valid with stall low
   task automatic wait_res(input string tag, input int lat);
      int bad = 0;
      for (int c = 1; c < lat; c++) begin
         if ({valid, busy} !== 2'b01) bad++;
         tick();
      end
      chk({tag, "_busy_window"}, 64'(bad), 64'd0);
      chk({tag, "_valid"}, {61'd0, valid, busy, stall}, 64'b100);
   endtask
   task automatic chk_res(input string tag, input logic [31:0] h, input logic [31:0] l, input logic z);
      chk({tag, "_hi"}, {32'd0, hi}, {32'd0, h});
      chk({tag, "_lo"}, {32'd0, lo}, {32'd0, l});
      chk({tag, "_dz"}, {63'd0, dz}, {63'd0, z});
   endtask
   task automatic after_valid(input string tag, input logic [31:0] h, input logic [31:0] l);
      tick();
      chk({tag, "_one_shot"}, {62'd0, valid, dz}, 64'd0);
      chk({tag, "_hold"}, {hi, lo}, {h, l});
   endtask
   initial begin
      tick(); tick();
      rst = 1'b0;
      chk("reset_outs", {29'd0, busy, stall, valid, dz, 1'b0}, 64'd0);
      chk("reset_hilo", {hi, lo}, 64'd0);
      start = 1'b1; op = 2'b01;
      #1 chk("stall_follows_start", {63'd0, stall}, 64'd1);
      start = 1'b0;
      tick();
      // MULT -3 * 5
      issue(2'b00, 32'hFFFFFFFD, 32'd5);
      wait_res("mult_neg", MUL_LAT);
      chk_res("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
      after_valid("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFF1);
      // DIVU 100 / 7
      issue(2'b11, 32'd100, 32'd7);
      wait_res("divu", 34);
      chk_res("divu", 32'd2, 32'd14, 1'b0);
      tick();
      // DIV -7 / 2
      issue(2'b10, 32'hFFFFFFF9, 32'd2);
      wait_res("div_neg", 34);
      chk_res("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      tick();
      // DIV most-negative / -1 wraps
      issue(2'b10, 32'h80000000, 32'hFFFFFFFF);
      wait_res("div_ovf", 34);
      chk_res("div_ovf", 32'd0, 32'h80000000, 1'b0);
      tick();
      // DIVU 5 / 0
      issue(2'b11, 32'd5, 32'd0);
      wait_res("div_zero", 2);
      chk_res("div_zero", 32'd5, 32'hFFFFFFFF, 1'b1);
      after_valid("div_zero", 32'd5, 32'hFFFFFFFF);
      // DIVU flushed in cycle 10, MULTU 6*7 issued in cycle 11
      issue(2'b11, 32'd100, 32'd7);
      for (int c = 1; c < 10; c++) tick();
      flush = 1'b1;
      chk("flush_pre_busy", {63'd0, busy}, 64'd1);
      tick();
      flush = 1'b0;
      chk("flush_idle", {62'd0, busy, valid}, 64'd0);
      chk("flush_hold", {hi, lo}, {32'd5, 32'hFFFFFFFF});
      issue(2'b01, 32'd6, 32'd7);
      wait_res("multu_small", MUL_LAT);
      chk_res("multu_small", 32'd0, 32'd42, 1'b0);
      tick();
      // MULTU max*max with DIVU 9/3 issued in its valid cycle
      issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_res("multu_max", MUL_LAT);
      chk_res("multu_max", 32'hFFFFFFFE, 32'd1, 1'b0);
      issue(2'b11, 32'd9, 32'd3);
      wait_res("b2b_divu", 34);
      chk_res("b2b_divu", 32'd0, 32'd3, 1'b0);
      tick();
      // reset in cycle 15 of a DIV
      issue(2'b10, 32'd100, 32'd7);
      for (int c = 1; c < 15; c++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_outs", {60'd0, busy, stall, valid, dz}, 64'd0);
      chk("midrst_hilo", {hi, lo}, 64'd0);
      start = 1'b1; op = 2'b00;
      #1 chk("midrst_stall_start", {63'd0, stall}, 64'd1);
      start = 1'b0;
      begin
         int bad = 0;
         for (int c = 0; c < 40; c++) begin
            if (valid !== 1'b0 || busy !== 1'b0) bad++;
            tick();
         end
         chk("midrst_quiet", 64'(bad), 64'd0);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
